// File: rtl/div_ratio_meter.sv
// Recovers period/high time of a divided clock sampled on clk_in; reports one cycle after the closing rise.
// Free-running monitor with no backpressure: meas_valid and timeout are single-cycle pulses.
module div_ratio_meter #(
  parameter int W          = 8,
  parameter int MAX_PERIOD = 255,
  parameter int LOCK_COUNT = 2
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         meas_valid,
  output logic         even_duty,
  output logic         locked,
  output logic         timeout
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0]  MAXP      = W'(MAX_PERIOD);
  localparam logic [MW-1:0] LC        = MW'(LOCK_COUNT);
  localparam logic          LOCK_INIT = (LOCK_COUNT == 1);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  state_t        r_state, w_state;
  logic          r_s_d;
  logic [W-1:0]  r_per_cnt, w_per_cnt;
  logic [W-1:0]  r_hi_cnt, w_hi_cnt;
  logic [MW-1:0] r_match_cnt, w_match_cnt;
  logic [W-1:0]  r_ref_per, w_ref_per;
  logic [W-1:0]  r_ref_hi, w_ref_hi;
  logic [W-1:0]  r_period, w_period;
  logic [W-1:0]  r_high, w_high;
  logic          r_valid, w_valid;
  logic          r_even, w_even;
  logic          r_locked, w_locked;
  logic          r_timeout, w_timeout;

  logic          w_rise;
  logic          w_even_new;
  logic          w_same_ref;
  logic [MW-1:0] w_match_inc;

  assign w_rise      = sig_in & ~r_s_d;
  assign w_even_new  = ~r_per_cnt[0] && (r_hi_cnt == (r_per_cnt >> 1));
  assign w_same_ref  = (r_per_cnt == r_ref_per) && (r_hi_cnt == r_ref_hi);
  assign w_match_inc = (r_match_cnt >= LC) ? r_match_cnt : r_match_cnt + MW'(1);

  always_comb begin
    w_state     = r_state;
    w_per_cnt   = r_per_cnt;
    w_hi_cnt    = r_hi_cnt;
    w_match_cnt = r_match_cnt;
    w_ref_per   = r_ref_per;
    w_ref_hi    = r_ref_hi;
    w_period    = r_period;
    w_high      = r_high;
    w_even      = r_even;
    w_locked    = r_locked;
    w_valid     = 1'b0;
    w_timeout   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_per_cnt = W'(1);
          w_hi_cnt  = W'(1);
          w_state   = ARMED;
        end else begin
          w_per_cnt = '0;
          w_hi_cnt  = '0;
        end
      end

      ARMED, TRACK: begin
        // A rise on the MAX_PERIOD cycle is a valid measurement, so it takes priority.
        if (w_rise) begin
          w_per_cnt = W'(1);
          w_hi_cnt  = W'(1);
          w_period  = r_per_cnt;
          w_high    = r_hi_cnt;
          w_even    = w_even_new;
          w_valid   = 1'b1;
          w_state   = TRACK;
          if ((r_state == TRACK) && w_same_ref) begin
            w_match_cnt = w_match_inc;
            if (w_match_inc == LC) begin
              w_locked = 1'b1;
            end
          end else begin
            w_ref_per   = r_per_cnt;
            w_ref_hi    = r_hi_cnt;
            w_match_cnt = MW'(1);
            w_locked    = LOCK_INIT;
          end
        end else if (r_per_cnt == MAXP) begin
          w_timeout   = 1'b1;
          w_locked    = 1'b0;
          w_match_cnt = '0;
          w_per_cnt   = '0;
          w_hi_cnt    = '0;
          w_state     = IDLE;
        end else begin
          w_per_cnt = r_per_cnt + W'(1);
          w_hi_cnt  = r_hi_cnt + W'(sig_in);
        end
      end

      default: begin
        w_state   = IDLE;
        w_per_cnt = '0;
        w_hi_cnt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_s_d       <= 1'b0;
      r_per_cnt   <= '0;
      r_hi_cnt    <= '0;
      r_match_cnt <= '0;
      r_ref_per   <= '0;
      r_ref_hi    <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_even      <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_s_d       <= sig_in;
      r_per_cnt   <= w_per_cnt;
      r_hi_cnt    <= w_hi_cnt;
      r_match_cnt <= w_match_cnt;
      r_ref_per   <= w_ref_per;
      r_ref_hi    <= w_ref_hi;
      r_period    <= w_period;
      r_high      <= w_high;
      r_valid     <= w_valid;
      r_even      <= w_even;
      r_locked    <= w_locked;
      r_timeout   <= w_timeout;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high;
  assign meas_valid = r_valid;
  assign even_duty  = r_even;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_div_ratio_meter.sv
// Scoreboard bench for div_ratio_meter: a cycle-indexed reference model queues expected reports/timeouts.
module tb_div_ratio_meter;

  localparam int W    = 8;
  localparam int MAXP = 20;
  localparam int LOCK = 2;

  logic         clk_in;
  logic         reset_n;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         even_duty;
  logic         locked;
  logic         timeout;

  div_ratio_meter #(.W(W), .MAX_PERIOD(MAXP), .LOCK_COUNT(LOCK)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .even_duty (even_duty),
    .locked    (locked),
    .timeout   (timeout)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct {
    int cyc;
    int per;
    int hi;
    int even;
    int lck;
  } exp_t;

  exp_t rep_q[$];
  exp_t to_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen/missing at t=%0t", name, $time);
  endtask

  // Reference model: periods are differences of rise cycle indices, high time is a sum of samples.
  int cyc = 0;
  int armed = 0;
  int prev = 0;
  int last_rise = 0;
  int hi_sum = 0;
  int last_p = 0, last_h = 0, last_e = 0;
  int hist_p[$];
  int hist_h[$];

  function automatic int model_locked();
    int n;
    n = hist_p.size();
    if (n < LOCK) return 0;
    for (int k = n - LOCK; k < n; k++)
      if (hist_p[k] != hist_p[n-1] || hist_h[k] != hist_h[n-1]) return 0;
    return 1;
  endfunction

  always @(posedge clk_in) begin
    int s;
    int rise;
    exp_t e;
    cyc++;
    if (!reset_n) begin
      armed = 0; prev = 0; hi_sum = 0;
      last_p = 0; last_h = 0; last_e = 0;
      hist_p.delete(); hist_h.delete();
      rep_q.delete(); to_q.delete();
    end else begin
      s = int'(sig_in);
      rise = (s == 1 && prev == 0) ? 1 : 0;
      if (armed != 0 && rise != 0) begin
        last_p = cyc - last_rise;
        last_h = hi_sum;
        last_e = (last_p % 2 == 0 && last_h == last_p / 2) ? 1 : 0;
        hist_p.push_back(last_p);
        hist_h.push_back(last_h);
        e = '{cyc: cyc, per: last_p, hi: last_h, even: last_e, lck: model_locked()};
        rep_q.push_back(e);
      end else if (armed != 0 && cyc - last_rise == MAXP) begin
        armed = 0;
        hist_p.delete(); hist_h.delete();
        e = '{cyc: cyc, per: last_p, hi: last_h, even: last_e, lck: 0};
        to_q.push_back(e);
      end
      if (rise != 0) begin
        armed = 1;
        last_rise = cyc;
        hi_sum = 1;
      end else begin
        hi_sum += s;
      end
      prev = s;
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the matching queue.
  always @(negedge clk_in) begin
    exp_t e;
    if (reset_n) begin
      while (rep_q.size() > 0 && rep_q[0].cyc < cyc) begin
        flag_fail("missing_meas_valid");
        void'(rep_q.pop_front());
      end
      while (to_q.size() > 0 && to_q[0].cyc < cyc) begin
        flag_fail("missing_timeout");
        void'(to_q.pop_front());
      end
      if (meas_valid) begin
        if (rep_q.size() == 0) flag_fail("unexpected_meas_valid");
        else begin
          e = rep_q.pop_front();
          chk("report_cycle", cyc, e.cyc);
          chk("period", int'(period), e.per);
          chk("high_time", int'(high_time), e.hi);
          chk("even_duty", int'(even_duty), e.even);
          chk("locked", int'(locked), e.lck);
          chk("no_timeout_with_report", int'(timeout), 0);
        end
      end
      if (timeout) begin
        if (to_q.size() == 0) flag_fail("unexpected_timeout");
        else begin
          e = to_q.pop_front();
          chk("timeout_cycle", cyc, e.cyc);
          chk("timeout_locked", int'(locked), 0);
          chk("timeout_period_hold", int'(period), e.per);
          chk("timeout_high_hold", int'(high_time), e.hi);
          chk("timeout_even_hold", int'(even_duty), e.even);
        end
      end
    end
  end

  task automatic drive(input logic b);
    @(negedge clk_in);
    sig_in = b;
  endtask

  task automatic pat(input int p, input int h, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < p; i++)
        drive(i < h);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) drive(b);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_time"}, int'(high_time), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_even_duty"}, int'(even_duty), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    sig_in  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;

    pat(2, 1, 6);
    pat(4, 2, 5);
    pat(6, 3, 3);
    pat(4, 1, 3);
    hold(1'b0, 30);
    pat(4, 2, 3);
    pat(20, 1, 3);
    pat(21, 1, 3);
    hold(1'b1, 30);
    hold(1'b0, 2);

    // Asynchronous reset in the middle of a tracked period.
    pat(5, 2, 3);
    drive(1'b1);
    drive(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    pat(3, 1, 4);

    for (int it = 0; it < 25; it++) begin
      int p;
      int h;
      p = int'($urandom_range(2, 24));
      h = int'($urandom_range(1, p - 1));
      pat(p, h, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 4) == 0) hold(1'($urandom_range(0, 1)), int'($urandom_range(22, 30)));
    end
    for (int i = 0; i < 150; i++) drive(1'($urandom_range(0, 1)));

    hold(1'b0, 25);
    repeat (2) @(negedge clk_in);
    chk("reports_drained", rep_q.size(), 0);
    chk("timeouts_drained", to_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
